// File: rtl/ufir_ramp_checker.sv
// Scores UFIR DUT output pairs against golden-model ramp samples, which are captured once
// per overclocking period into a small reference FIFO. Keeps pass/fail counters and sticky flags.
module ufir_ramp_checker #(
  parameter int OVERCLOCKING_FACTOR = 5,
  parameter int DATA_W              = 16,
  parameter int TOLERANCE           = 0,
  parameter int FIFO_DEPTH          = 8,
  parameter int WARMUP_SAMPLES      = 0,
  parameter int CNT_W               = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clk_enable,
  input  logic [DATA_W-1:0]           ref_dpi_1,
  input  logic [DATA_W-1:0]           ref_dpi_2,
  input  logic                        dut_valid,
  input  logic [DATA_W-1:0]           dut_out_1,
  input  logic [DATA_W-1:0]           dut_out_2,
  output logic                        cmp_valid,
  output logic [1:0]                  mismatch,
  output logic [CNT_W-1:0]            sample_cnt,
  output logic [CNT_W-1:0]            err_cnt_1,
  output logic [CNT_W-1:0]            err_cnt_2,
  output logic [CNT_W-1:0]            first_err_index,
  output logic                        ref_overflow,
  output logic                        ref_underflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        pass
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int PH_W  = $clog2(OVERCLOCKING_FACTOR + 1);

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [DATA_W:0]   wide_t;
  typedef logic [LVL_W-1:0]  lvl_t;
  typedef logic [PH_W-1:0]   phase_t;
  typedef enum logic [1:0] {ST_WARMUP, ST_CHECK, ST_FAIL} state_t;

  localparam phase_t PH_LAST  = phase_t'(OVERCLOCKING_FACTOR);
  localparam lvl_t   LVL_FULL = lvl_t'(FIFO_DEPTH);
  localparam wide_t  TOL      = wide_t'(TOLERANCE);
  localparam cnt_t   WARM_N   = cnt_t'(WARMUP_SAMPLES);
  localparam cnt_t   CNT_MAX  = '1;
  localparam state_t ST_RESET = (WARMUP_SAMPLES > 0) ? ST_WARMUP : ST_CHECK;

  // Difference is taken one bit wider than the data so full-scale opposite extremes cannot wrap.
  function automatic wide_t abs_diff(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    wide_t d;
    d = {a[DATA_W-1], a} - {b[DATA_W-1], b};
    return d[DATA_W] ? -d : d;
  endfunction

  function automatic cnt_t sat_inc(input cnt_t c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  logic [DATA_W-1:0] mem_1 [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_2 [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  phase_t            phase;
  state_t            state;
  cnt_t              warm_cnt;
  logic              err_seen;

  logic       empty, full, push, pop_req, do_pop, push_ok;
  logic       overflow_ev, underflow_ev, scored;
  logic [1:0] mm;

  assign empty        = (fifo_level == '0);
  assign full         = (fifo_level == LVL_FULL);
  assign push         = clk_enable && (phase == PH_LAST);
  assign pop_req      = clk_enable && dut_valid;
  assign do_pop       = pop_req && !empty;
  assign push_ok      = push && (!full || do_pop);
  assign overflow_ev  = push && full && !do_pop;
  assign underflow_ev = pop_req && empty;
  assign scored       = do_pop && (state != ST_WARMUP);
  assign mm           = {abs_diff(dut_out_2, mem_2[rd_ptr]) > TOL,
                         abs_diff(dut_out_1, mem_1[rd_ptr]) > TOL};

  // NOTE: storage array has no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_1[wr_ptr] <= ref_dpi_1;
      mem_2[wr_ptr] <= ref_dpi_2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase           <= phase_t'(1);
      state           <= ST_RESET;
      warm_cnt        <= '0;
      err_seen        <= 1'b0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_level      <= '0;
      cmp_valid       <= 1'b0;
      mismatch        <= 2'b00;
      sample_cnt      <= '0;
      err_cnt_1       <= '0;
      err_cnt_2       <= '0;
      first_err_index <= '1;
      ref_overflow    <= 1'b0;
      ref_underflow   <= 1'b0;
      pass            <= 1'b1;
    end else if (!clk_enable) begin
      cmp_valid <= 1'b0;
    end else begin
      phase     <= (phase == PH_LAST) ? phase_t'(1) : phase + 1'b1;
      cmp_valid <= 1'b0;
      mismatch  <= 2'b00;

      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, do_pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: ;
      endcase

      if (do_pop && state == ST_WARMUP) begin
        warm_cnt <= warm_cnt + 1'b1;
        if (warm_cnt + 1'b1 == WARM_N) state <= ST_CHECK;
      end

      if (scored) begin
        cmp_valid  <= 1'b1;
        mismatch   <= mm;
        sample_cnt <= sat_inc(sample_cnt);
        if (mm[0]) err_cnt_1 <= sat_inc(err_cnt_1);
        if (mm[1]) err_cnt_2 <= sat_inc(err_cnt_2);
        if (mm != 2'b00) begin
          pass <= 1'b0;
          if (!err_seen) begin
            err_seen        <= 1'b1;
            first_err_index <= sample_cnt;
          end
        end
      end

      if (overflow_ev) begin
        ref_overflow <= 1'b1;
        pass         <= 1'b0;
      end
      if (underflow_ev) begin
        ref_underflow <= 1'b1;
        pass          <= 1'b0;
      end

      if (state == ST_CHECK && ((scored && mm != 2'b00) || overflow_ev || underflow_ev))
        state <= ST_FAIL;
    end
  end

endmodule

// File: tb/tb_ufir_ramp_checker.sv
// Directed bench for ufir_ramp_checker: a strict instance (TOLERANCE 0) checked through a
// mismatch scoreboard, and a lenient warmup instance (TOLERANCE 100, 5 warmup pops) on shared inputs.
module tb_ufir_ramp_checker;

  localparam int OF = 5;

  logic clk = 1'b0;
  logic reset, clk_enable, dut_valid;
  logic signed [15:0] ref_dpi_1, ref_dpi_2, dut_out_1, dut_out_2;

  logic        cmp_valid, ref_overflow, ref_underflow, pass;
  logic [1:0]  mismatch;
  logic [31:0] sample_cnt, err_cnt_1, err_cnt_2, first_err_index;
  logic [3:0]  fifo_level;

  logic        w_cmp_valid, w_ref_overflow, w_ref_underflow, w_pass;
  logic [1:0]  w_mismatch;
  logic [31:0] w_sample_cnt, w_err_cnt_1, w_err_cnt_2, w_first_err_index;
  logic [3:0]  w_fifo_level;

  ufir_ramp_checker u_dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .ref_dpi_1(ref_dpi_1), .ref_dpi_2(ref_dpi_2),
    .dut_valid(dut_valid), .dut_out_1(dut_out_1), .dut_out_2(dut_out_2),
    .cmp_valid(cmp_valid), .mismatch(mismatch), .sample_cnt(sample_cnt),
    .err_cnt_1(err_cnt_1), .err_cnt_2(err_cnt_2), .first_err_index(first_err_index),
    .ref_overflow(ref_overflow), .ref_underflow(ref_underflow),
    .fifo_level(fifo_level), .pass(pass)
  );

  ufir_ramp_checker #(.TOLERANCE(100), .WARMUP_SAMPLES(5)) u_wide (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .ref_dpi_1(ref_dpi_1), .ref_dpi_2(ref_dpi_2),
    .dut_valid(dut_valid), .dut_out_1(dut_out_1), .dut_out_2(dut_out_2),
    .cmp_valid(w_cmp_valid), .mismatch(w_mismatch), .sample_cnt(w_sample_cnt),
    .err_cnt_1(w_err_cnt_1), .err_cnt_2(w_err_cnt_2), .first_err_index(w_first_err_index),
    .ref_overflow(w_ref_overflow), .ref_underflow(w_ref_underflow),
    .fifo_level(w_fifo_level), .pass(w_pass)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Stimulus tables, bench phase/FIFO model and expected counters
  logic signed [15:0] ref1_tab [256];
  logic signed [15:0] ref2_tab [256];
  logic signed [15:0] dut1_tab [256];
  logic signed [15:0] dut2_tab [256];
  logic signed [15:0] rq1[$];
  logic signed [15:0] rq2[$];
  logic [1:0]         exp_q[$];
  logic [1:0]         mon_exp;
  int ph, cap_k, j, max_level;
  int e_samples, e_err1, e_err2, e_first;
  int w_pops, e2_samples, e2_err1, e2_err2, e2_first;
  bit e_seen, e2_seen, m_ovf, m_unf;

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic load_ramp();
    for (int i = 0; i < 256; i++) begin
      ref1_tab[i] = 16'(i); ref2_tab[i] = 16'(i);
      dut1_tab[i] = 16'(i); dut2_tab[i] = 16'(i);
    end
  endtask

  task automatic model_reset();
    rq1.delete(); rq2.delete(); exp_q.delete();
    ph = 1; cap_k = 0; j = 0; max_level = 0;
    e_samples = 0; e_err1 = 0; e_err2 = 0; e_first = 0; e_seen = 0;
    w_pops = 0; e2_samples = 0; e2_err1 = 0; e2_err2 = 0; e2_first = 0; e2_seen = 0;
    m_ovf = 0; m_unf = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; clk_enable = 1'b0; dut_valid = 1'b0;
    dut_out_1 = '0; dut_out_2 = '0;
    model_reset();
    ref_dpi_1 = ref1_tab[0]; ref_dpi_2 = ref2_tab[0];
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One clock: apply inputs, then model the edge (pop before push, no bypass).
  task automatic step(input bit en, input bit dv, input logic signed [15:0] d1,
                      input logic signed [15:0] d2);
    logic signed [15:0] r1, r2;
    logic [1:0] m;
    bit cap;
    clk_enable = en; dut_valid = dv; dut_out_1 = d1; dut_out_2 = d2;
    @(posedge clk);
    cap = 0;
    if (en) begin
      if (dv) begin
        if (rq1.size() > 0) begin
          r1 = rq1.pop_front(); r2 = rq2.pop_front();
          m[0] = iabs(int'(d1) - int'(r1)) > 0;
          m[1] = iabs(int'(d2) - int'(r2)) > 0;
          exp_q.push_back(m);
          if (m != 2'b00 && !e_seen) begin e_seen = 1; e_first = e_samples; end
          e_samples++;
          if (m[0]) e_err1++;
          if (m[1]) e_err2++;
          if (w_pops < 5) w_pops++;
          else begin
            m[0] = iabs(int'(d1) - int'(r1)) > 100;
            m[1] = iabs(int'(d2) - int'(r2)) > 100;
            if (m != 2'b00 && !e2_seen) begin e2_seen = 1; e2_first = e2_samples; end
            e2_samples++;
            if (m[0]) e2_err1++;
            if (m[1]) e2_err2++;
          end
          j++;
        end else m_unf = 1;
      end
      if (ph == OF) begin
        if (rq1.size() < 8) begin rq1.push_back(ref_dpi_1); rq2.push_back(ref_dpi_2); end
        else m_ovf = 1;
        cap_k++; cap = 1;
      end
      ph = (ph == OF) ? 1 : ph + 1;
    end
    #1;
    if (cap) begin ref_dpi_1 = ref1_tab[cap_k % 256]; ref_dpi_2 = ref2_tab[cap_k % 256]; end
  endtask

  // DUT pops at the phase-3 edge once `lag`+1 references have been captured.
  task automatic run_stream(input int target, input int lag);
    int budget;
    budget = 0;
    while (j < target && budget < 2000) begin
      if (ph == 3 && cap_k >= lag + 1 && rq1.size() > 0) step(1, 1, dut1_tab[j], dut2_tab[j]);
      else step(1, 0, '0, '0);
      budget++;
    end
    check("stream_budget", j, target);
  endtask

  task automatic drain();
    repeat (2) step(1, 0, '0, '0);
  endtask

  task automatic check_reset_vals(input string t);
    check({t, "_cmp_valid"}, cmp_valid, 0);
    check({t, "_mismatch"}, mismatch, 0);
    check({t, "_sample_cnt"}, sample_cnt, 0);
    check({t, "_err_cnt_1"}, err_cnt_1, 0);
    check({t, "_err_cnt_2"}, err_cnt_2, 0);
    check({t, "_first_err"}, first_err_index, 32'hFFFF_FFFF);
    check({t, "_ovf"}, ref_overflow, 0);
    check({t, "_unf"}, ref_underflow, 0);
    check({t, "_level"}, fifo_level, 0);
    check({t, "_pass"}, pass, 1);
    check({t, "_w_sample_cnt"}, w_sample_cnt, 0);
    check({t, "_w_level"}, w_fifo_level, 0);
    check({t, "_w_pass"}, w_pass, 1);
  endtask

  task automatic check_all(input string t);
    logic [31:0] ef, ef2;
    ef  = e_seen  ? 32'(e_first)  : 32'hFFFF_FFFF;
    ef2 = e2_seen ? 32'(e2_first) : 32'hFFFF_FFFF;
    check({t, "_sample_cnt"}, sample_cnt, e_samples);
    check({t, "_err_cnt_1"}, err_cnt_1, e_err1);
    check({t, "_err_cnt_2"}, err_cnt_2, e_err2);
    check({t, "_first_err"}, first_err_index, ef);
    check({t, "_ovf"}, ref_overflow, m_ovf);
    check({t, "_unf"}, ref_underflow, m_unf);
    check({t, "_level"}, fifo_level, rq1.size());
    check({t, "_pass"}, pass, (e_err1 == 0 && e_err2 == 0 && !m_ovf && !m_unf));
    check({t, "_pending_cmp"}, exp_q.size(), 0);
    check({t, "_w_sample_cnt"}, w_sample_cnt, e2_samples);
    check({t, "_w_err_cnt_1"}, w_err_cnt_1, e2_err1);
    check({t, "_w_err_cnt_2"}, w_err_cnt_2, e2_err2);
    check({t, "_w_first_err"}, w_first_err_index, ef2);
    check({t, "_w_level"}, w_fifo_level, rq1.size());
    check({t, "_w_pass"}, w_pass, (e2_err1 == 0 && e2_err2 == 0 && !m_ovf && !m_unf));
  endtask

  // Scoreboard monitor: every cmp_valid pulse must match the oldest expected mismatch.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
      if (cmp_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_cmp: got cmp_valid=1 mismatch=%b expected no compare", mismatch);
        end else begin
          mon_exp = exp_q.pop_front();
          check("mismatch", mismatch, mon_exp);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic signed [15:0] sv1, sv2;

    // Ramp match, then a single ch2 +1 error at sample 10
    load_ramp();
    dut2_tab[10] = 16'sd11;
    do_reset();
    check_reset_vals("init");
    run_stream(10, 3);
    drain();
    check("ramp10_pass", pass, 1);
    check("ramp10_err_cnt_2", err_cnt_2, 0);
    check("ramp10_sample_cnt", sample_cnt, 10);
    run_stream(100, 3);
    drain();
    check_all("ramp");
    check("ramp_sample_cnt", sample_cnt, 100);
    check("ramp_err_cnt_1", err_cnt_1, 0);
    check("ramp_err_cnt_2", err_cnt_2, 1);
    check("ramp_first_err", first_err_index, 10);
    check("ramp_pass", pass, 0);
    check("ramp_max_level", max_level, 4);
    check("ramp_w_sample_cnt", w_sample_cnt, 95);
    check("ramp_w_pass", w_pass, 1);

    // Extremes and tolerance boundary (100 passes, 101 fails on the lenient instance)
    load_ramp();
    ref1_tab[5] = -16'sd32768; ref2_tab[5] = 16'sd32767;
    dut1_tab[5] = 16'sd32767;  dut2_tab[5] = -16'sd32768;
    dut1_tab[6] = 16'sd106;    dut2_tab[7] = -16'sd94;
    do_reset();
    run_stream(8, 1);
    drain();
    check_all("ext");
    check("ext_err_cnt_1", err_cnt_1, 2);
    check("ext_err_cnt_2", err_cnt_2, 2);
    check("ext_first_err", first_err_index, 5);
    check("ext_w_sample_cnt", w_sample_cnt, 3);
    check("ext_w_err_cnt_1", w_err_cnt_1, 1);
    check("ext_w_err_cnt_2", w_err_cnt_2, 2);

    // Overflow: no DUT data for 9 reference periods, then push+pop while full
    load_ramp();
    do_reset();
    repeat (9 * OF) step(1, 0, '0, '0);
    check("ovf_flag", ref_overflow, 1);
    check("ovf_level", fifo_level, 8);
    check("ovf_pass", pass, 0);
    check_all("ovf");
    while (ph != OF) step(1, 0, '0, '0);
    step(1, 1, 16'sd0, 16'sd0);
    check("full_pushpop_level", fifo_level, 8);
    run_stream(9, 0);
    drain();
    check_all("ovf_drain");
    check("ovf_drain_err_cnt_1", err_cnt_1, 1);
    check("ovf_drain_first_err", first_err_index, 8);

    // Underflow: DUT data before the first capture, then simultaneous push on empty
    load_ramp();
    do_reset();
    step(1, 1, 16'sd0, 16'sd0);
    step(1, 0, '0, '0);
    check("unf_flag", ref_underflow, 1);
    check("unf_sample_cnt", sample_cnt, 0);
    check("unf_pass", pass, 0);
    while (ph != OF) step(1, 0, '0, '0);
    step(1, 1, 16'sd0, 16'sd0);
    check("unf_push_level", fifo_level, 1);
    step(1, 1, 16'sd0, 16'sd0);
    drain();
    check_all("unf");
    check("unf_sample_cnt_after", sample_cnt, 1);

    // Warmup with corrupted first 5 samples, plus a 7-cycle clk_enable freeze
    load_ramp();
    for (int i = 0; i < 5; i++) begin
      dut1_tab[i] = 16'(i + 500); dut2_tab[i] = 16'(i + 500);
    end
    do_reset();
    run_stream(6, 1);
    sv1 = ref_dpi_1; sv2 = ref_dpi_2;
    ref_dpi_1 = 16'sh7777; ref_dpi_2 = 16'sh7777;
    repeat (7) step(0, 1, 16'sh1234, 16'sh1234);
    check_all("freeze");
    check("freeze_cmp_valid", cmp_valid, 0);
    ref_dpi_1 = sv1; ref_dpi_2 = sv2;
    run_stream(10, 1);
    drain();
    check_all("warm");
    check("warm_err_cnt_1", err_cnt_1, 5);
    check("warm_first_err", first_err_index, 0);
    check("warm_w_sample_cnt", w_sample_cnt, 5);
    check("warm_w_err_cnt_2", w_err_cnt_2, 0);
    check("warm_w_pass", w_pass, 1);

    // Reset mid-run after 50 compares with 2 errors, then a clean restart
    load_ramp();
    dut1_tab[20] = 16'sd21; dut2_tab[30] = 16'sd29;
    do_reset();
    run_stream(50, 2);
    drain();
    check_all("pre_rst");
    check("pre_rst_sample_cnt", sample_cnt, 50);
    check("pre_rst_first_err", first_err_index, 20);
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("midrst");
    load_ramp();
    do_reset();
    run_stream(10, 2);
    drain();
    check_all("restart");
    check("restart_sample_cnt", sample_cnt, 10);
    check("restart_pass", pass, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ufir_ramp_checker.md
Name: ufir_ramp_checker

Overview:
- Downstream consumer of the ramp golden-model DPI stage. It samples the two 16-bit reference outputs, dpi_1 and dpi_2, once per overclocking period and buffers them in a reference FIFO.
- Each reference pair is compared, within a tolerance, against the UFIR DUT output pair as the DUT output arrives.
- Mismatch, sample and error counters and sticky flags drive the testbench scoreboard and the end-of-test pass/fail.

Parameters:
- OVERCLOCKING_FACTOR, 5, clock cycles per golden-model sample. Must be >=2; matches the golden-model stage.
- DATA_W, 16, sample width, signed two's complement.
- TOLERANCE, 0, maximum allowed |dut - ref| per channel, in LSBs.
- FIFO_DEPTH, 8, reference FIFO entries. Power of two.
- WARMUP_SAMPLES, 0, number of initial compares that pop but are not scored.
- CNT_W, 32, counter width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high. Clears all state.
- clk_enable  in  1  global enable. No state changes when low.
- ref_dpi_1  in  DATA_W  golden-model channel 1 (signed).
- ref_dpi_2  in  DATA_W  golden-model channel 2 (signed).
- dut_valid  in  1  DUT output pair valid this cycle.
- dut_out_1  in  DATA_W  DUT channel 1 (signed).
- dut_out_2  in  DATA_W  DUT channel 2 (signed).
- cmp_valid  out  1  a scored compare completed (registered pulse).
- mismatch  out  2  per-channel mismatch for the compare; bit0 = ch1, bit1 = ch2. Qualified by cmp_valid.
- sample_cnt  out  CNT_W  scored compares.
- err_cnt_1  out  CNT_W  channel 1 mismatches.
- err_cnt_2  out  CNT_W  channel 2 mismatches.
- first_err_index  out  CNT_W  sample_cnt value at the first mismatch.
- ref_overflow  out  1  sticky: a reference push occurred while the FIFO was full.
- ref_underflow  out  1  sticky: dut_valid arrived while the FIFO was empty.
- fifo_level  out  clog2(FIFO_DEPTH)+1  current reference FIFO occupancy.
- pass  out  1  high while there are no mismatches and no overflow/underflow.

Behaviour:
- Reset values:
  - all counters 0; cmp_valid, mismatch, ref_overflow, ref_underflow 0.
  - fifo_level 0; pass 1; first_err_index all-ones.
  - internal phase counter 1; state WARMUP (state CHECK when WARMUP_SAMPLES=0).
- Phase counter:
  - Advances only on clk_enable edges.
  - Wraps from OVERCLOCKING_FACTOR back to 1, mirroring the golden-model counter.
  - Reference capture (push of {ref_dpi_2, ref_dpi_1}) happens on an enabled edge with phase == OVERCLOCKING_FACTOR. This is race-free because the golden model updated at its phase-1 edge.
- FIFO:
  - Push when full: the data is dropped, ref_overflow is set and pass is cleared.
  - Push and pop on the same edge while full: both succeed and the level is unchanged.
  - No bypass. A pop while empty is an underflow, even with a simultaneous push; the push still stores its data.
- Pop and compare:
  - Occurs on an enabled edge with dut_valid=1 and a non-empty FIFO.
  - Arithmetic: diff = dut - ref, sign-extended to DATA_W+1 bits; abs in DATA_W+1 bits; mismatch bit = abs > TOLERANCE.
  - Extreme operands (-32768 vs 32767) must not wrap.
- Underflow: dut_valid with an empty FIFO sets ref_underflow and clears pass. No compare, no counter change.
- Latency: cmp_valid, mismatch and counter updates appear registered one cycle after the pop edge.
- State machine:
  - WARMUP: pops are counted by an internal warmup counter; cmp_valid stays 0; no scoring. Moves to CHECK after WARMUP_SAMPLES pops.
  - CHECK: every pop is scored. sample_cnt increments; err_cnt_n increments on a channel mismatch.
  - FAIL: entered from CHECK on the first mismatch, overflow or underflow. first_err_index latches sample_cnt (pre-increment) on the first mismatch only. Scoring continues in FAIL; the state is sticky until reset.
- Counters saturate at all-ones and never wrap.
- clk_enable low: the phase counter, FIFO and counters all hold; cmp_valid drops to 0.
- Reset asserted mid-run: immediate asynchronous clear to reset values. The FIFO contents are discarded.

Test Plan:
- Ramp match: ref and DUT both follow the ramp 0,1,2,..., DUT delayed 3 samples, 100 samples -> sample_cnt=100, err_cnt_1=err_cnt_2=0, pass=1, fifo_level never exceeds 4.
- Single error: DUT ch2 sample 10 offset +1, TOLERANCE=0 -> mismatch=2'b10 pulse at that compare, err_cnt_2=1, first_err_index=10, pass=0. With TOLERANCE=1 -> no error.
- Extremes: ref=-32768, DUT=32767 with TOLERANCE=100 -> mismatch asserted, no arithmetic wrap.
- Overflow/underflow: hold dut_valid low for 9 reference periods with FIFO_DEPTH=8 -> ref_overflow=1, fifo_level=8. After reset, dut_valid before the first capture -> ref_underflow=1, sample_cnt=0.
- Warmup and enable: WARMUP_SAMPLES=5 with corrupted samples 0-4 -> err_cnt=0 and sample_cnt counts from the 6th pop. Toggling clk_enable low for 7 cycles -> phase and counters frozen, no spurious capture.
- Reset mid-run after 50 compares with 2 errors -> all outputs return to reset values on reset assertion; the run then restarts cleanly.
